fir_inverse_decoder: RTL and testbench

Streaming inverse of the 4-tap moving-sum FIR, where every coefficient is 1. It takes the filtered stream y[n] and reconstructs the original samples with x[n] = y[n] − x[n−1] − … − x[n−N+1]. The block sits downstream of the FIR channel as its decoder. It uses valid/ready handshakes on both sides and a serial, one-tap-per-cycle subtract FSM.

---
 rtl/fir_inverse_decoder.sv | 124 ++++++++++++
 tb/tb_fir_inverse_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_inverse_decoder.sv
// fir_inverse_decoder
//   Streaming inverse of an N-tap all-ones moving-sum FIR.
//   Rebuilds x[n] = y[n] - x[n-1] - ... - x[n-N+1] with one subtract per cycle.
//   The result is saturated to DATA_WIDTH bits. The clipped value is what enters history.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   y_in     in   filtered sample (DATA_WIDTH+4, signed)
//   y_valid  in   y_in holds a sample
//   y_ready  out  decoder idle and able to accept y_in
//   x_out    out  reconstructed sample (DATA_WIDTH, signed)
//   x_valid  out  x_out holds a sample
//   x_ready  in   consumer accepts x_out
//   x_ovf    out  x_out was saturated (qualified by x_valid)
module fir_inverse_decoder #(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [DATA_WIDTH+3:0]   y_in,
  input  logic                           y_valid,
  output logic                           y_ready,
  output logic signed [DATA_WIDTH-1:0]   x_out,
  output logic                           x_valid,
  input  logic                           x_ready,
  output logic                           x_ovf
);

  localparam int unsigned YW = DATA_WIDTH + 4;
  localparam int unsigned AW = DATA_WIDTH + 4 + $clog2(N) + 1;
  // Keep the history array and tap counter non-empty when N == 1.
  localparam int unsigned HN = (N > 1) ? N - 1 : 1;
  localparam int unsigned KW = (N > 2) ? $clog2(N) : 1;

  localparam logic signed [AW-1:0] SatMax = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SatMin = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StSub, StOut} state_e;

  state_e                        r_state;
  logic signed [AW-1:0]          r_acc;
  logic        [KW-1:0]          r_k;
  logic signed [DATA_WIDTH-1:0]  r_hist [1:HN];
  logic signed [DATA_WIDTH-1:0]  r_x_out;
  logic                          r_ovf;

  logic signed [DATA_WIDTH-1:0]  w_tap;
  logic signed [AW-1:0]          w_acc_y;
  logic signed [AW-1:0]          w_acc_sub;
  logic signed [AW-1:0]          w_acc_fin;
  logic signed [DATA_WIDTH-1:0]  w_sat;
  logic                          w_ovf;

  // Handshake flags come from state alone, so no input reaches them combinationally.
  assign y_ready = (r_state == StIdle);
  assign x_valid = (r_state == StOut);
  assign x_out   = r_x_out;
  assign x_ovf   = r_ovf;

  always_comb begin
    w_tap     = r_hist[r_k];
    w_acc_y   = {{(AW-YW){y_in[YW-1]}}, y_in};
    w_acc_sub = r_acc - {{(AW-DATA_WIDTH){w_tap[DATA_WIDTH-1]}}, w_tap};
    // Value the accumulator takes on the edge that enters OUT.
    w_acc_fin = (r_state == StIdle) ? w_acc_y : w_acc_sub;
    w_sat     = w_acc_fin[DATA_WIDTH-1:0];
    w_ovf     = 1'b0;
    if (w_acc_fin > SatMax) begin
      w_sat = SatMax[DATA_WIDTH-1:0];
      w_ovf = 1'b1;
    end else if (w_acc_fin < SatMin) begin
      w_sat = SatMin[DATA_WIDTH-1:0];
      w_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_acc   <= '0;
      r_k     <= '0;
      r_x_out <= '0;
      r_ovf   <= 1'b0;
      for (int j = 1; j <= HN; j++) r_hist[j] <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (y_valid) begin
            r_acc <= w_acc_y;
            r_k   <= KW'(1);
            if (N == 1) begin
              r_state <= StOut;
              r_x_out <= w_sat;
              r_ovf   <= w_ovf;
            end else begin
              r_state <= StSub;
            end
          end
        end
        StSub: begin
          r_acc <= w_acc_sub;
          r_k   <= r_k + KW'(1);
          if (r_k == KW'(N - 1)) begin
            r_state <= StOut;
            r_x_out <= w_sat;
            r_ovf   <= w_ovf;
          end
        end
        StOut: begin
          if (x_ready) begin
            // Clipped output becomes the newest history entry.
            for (int j = HN; j >= 2; j--) r_hist[j] <= r_hist[j-1];
            r_hist[1] <= r_x_out;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_inverse_decoder.sv
module tb_fir_inverse_decoder;

  localparam int DW = 8;
  localparam int YW = DW + 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed [YW-1:0] y_in = '0;
  logic drv_valid = 1'b0;
  logic x_ready   = 1'b0;
  logic sel       = 1'b0;  // 0: N=4 instance, 1: N=1 instance

  logic                 y_valid4, y_ready4, x_valid4, x_ovf4;
  logic signed [DW-1:0] x_out4;
  logic                 y_valid1, y_ready1, x_valid1, x_ovf1;
  logic signed [DW-1:0] x_out1;

  logic                 cur_ready, cur_xv, cur_ovf;
  logic signed [DW-1:0] cur_x;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign y_valid4  = drv_valid & ~sel;
  assign y_valid1  = drv_valid & sel;
  assign cur_ready = sel ? y_ready1 : y_ready4;
  assign cur_xv    = sel ? x_valid1 : x_valid4;
  assign cur_x     = sel ? x_out1   : x_out4;
  assign cur_ovf   = sel ? x_ovf1   : x_ovf4;

  fir_inverse_decoder #(.N(4), .DATA_WIDTH(DW)) u_dut4 (
    .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid4), .y_ready(y_ready4),
    .x_out(x_out4), .x_valid(x_valid4), .x_ready(x_ready), .x_ovf(x_ovf4)
  );

  fir_inverse_decoder #(.N(1), .DATA_WIDTH(DW)) u_dut1 (
    .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid1), .y_ready(y_ready1),
    .x_out(x_out1), .x_valid(x_valid1), .x_ready(x_ready), .x_ovf(x_ovf1)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; drv_valid = 1'b0; x_ready = 1'b0; y_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Wait for y_ready, present y, then count edges after acceptance until x_valid.
  task automatic wait_accept(input logic signed [YW-1:0] y, input logic rdy);
    int n;
    @(negedge clk);
    y_in = y; drv_valid = 1'b1; x_ready = rdy;
    n = 0;
    while (!cur_ready && n < 50) begin @(negedge clk); n++; end
    if (!cur_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_xvalid(output int lat);
    lat = 0;
    while (!cur_xv && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!cur_xv) check("xvalid_timeout", 0, 1);
  endtask

  task automatic xfer(input logic signed [YW-1:0] y, output logic signed [DW-1:0] xo,
                      output logic ov, output int lat);
    wait_accept(y, 1'b1);
    drv_valid = 1'b0;
    wait_xvalid(lat);
    xo = cur_x; ov = cur_ovf;
    @(posedge clk); #1;  // x_ready handshake edge
  endtask

  initial begin
    logic signed [DW-1:0] xo;
    logic ov;
    int lat, cnt;
    int gy[6] = '{1, 3, 6, 10, 9, 7};
    int gx[6] = '{1, 2, 3, 4, 0, 0};
    int ny[5] = '{-128, -256, -384, -512, -384};
    int nx[5] = '{-128, -128, -128, -128, 0};

    // Reset state, sampled while reset is held.
    repeat (2) @(posedge clk); #1;
    check("rst_y_ready", y_ready4, 1);
    check("rst_x_valid", x_valid4, 0);
    check("rst_x_out", x_out4, 0);
    check("rst_x_ovf", x_ovf4, 0);
    @(negedge clk); rst = 1'b1;

    // Golden sequence.
    for (int i = 0; i < 6; i++) begin
      xfer(YW'(gy[i]), xo, ov, lat);
      check($sformatf("gold_x%0d", i), xo, gx[i]);
      check($sformatf("gold_ovf%0d", i), ov, 0);
      check($sformatf("gold_lat%0d", i), lat, 3);
    end

    // Negative full-scale.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      xfer(YW'(ny[i]), xo, ov, lat);
      check($sformatf("neg_x%0d", i), xo, nx[i]);
      check($sformatf("neg_ovf%0d", i), ov, 0);
    end

    // Saturation: clipped value enters history.
    do_reset();
    xfer(YW'(200), xo, ov, lat);
    check("sat_x0", xo, 127);
    check("sat_ovf0", ov, 1);
    xfer(YW'(127), xo, ov, lat);
    check("sat_x1", xo, 0);
    check("sat_ovf1", ov, 0);

    // Backpressure with a pending new sample.
    do_reset();
    xfer(YW'(5), xo, ov, lat);
    check("bp_first", xo, 5);
    wait_accept(YW'(12), 1'b0);
    y_in = YW'(20);  // next sample held valid throughout the stall
    wait_xvalid(lat);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_xv%0d", i), x_valid4, 1);
      check($sformatf("bp_yr%0d", i), y_ready4, 0);
      check($sformatf("bp_x%0d", i), x_out4, 7);
      check($sformatf("bp_ovf%0d", i), x_ovf4, 0);
      @(posedge clk); #1;
    end
    @(negedge clk); x_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_yr", y_ready4, 1);
    check("bp_idle_xv", x_valid4, 0);
    @(posedge clk); #1;
    check("bp_accept_yr", y_ready4, 0);
    drv_valid = 1'b0;
    wait_xvalid(lat);
    check("bp_second", x_out4, 8);  // 20 - 7 - 5
    check("bp_second_lat", lat, 3);
    @(posedge clk); #1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (x_valid4) cnt++;
      @(posedge clk); #1;
    end
    check("bp_no_dup", cnt, 0);

    // Reset asserted in SUB.
    do_reset();
    xfer(YW'(1), xo, ov, lat);
    check("mid_first", xo, 1);
    wait_accept(YW'(3), 1'b1);
    drv_valid = 1'b0;
    check("mid_in_sub", y_ready4, 0);
    #2 rst = 1'b0;
    #1;
    check("mid_sub_yr", y_ready4, 1);
    check("mid_sub_xv", x_valid4, 0);
    check("mid_sub_x", x_out4, 0);
    @(negedge clk); rst = 1'b1;
    xfer(YW'(5), xo, ov, lat);
    check("mid_after", xo, 5);

    // Reset asserted in OUT drops x_valid without a clock edge.
    wait_accept(YW'(4), 1'b0);
    drv_valid = 1'b0;
    wait_xvalid(lat);
    check("out_xv_before", x_valid4, 1);
    #2 rst = 1'b0;
    #1;
    check("out_xv_async", x_valid4, 0);
    check("out_x_async", x_out4, 0);
    @(negedge clk); rst = 1'b1;

    // N = 1 instance.
    sel = 1'b1;
    do_reset();
    xfer(YW'(7), xo, ov, lat);
    check("n1_x0", xo, 7);
    check("n1_lat0", lat, 0);
    xfer(-YW'(9), xo, ov, lat);
    check("n1_x1", xo, -9);
    check("n1_lat1", lat, 0);
    xfer(YW'(200), xo, ov, lat);
    check("n1_sat", xo, 127);
    check("n1_sat_ovf", ov, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
